rotary_input_conditioner: RTL and testbench
===========================================

Name: rotary_input_conditioner

Overview:
Front-end conditioning stage between the raw rotary-encoder pins (A, B, push button) and the quadrature decoder in the MMIO subsystem. It synchronises each asynchronous pin into the clk domain with two flops and debounces it with a per-channel stability counter. It delivers glitch-free levels to the decoder, and single-cycle button press/release pulses for the MMIO wrapper.

Parameters:
DB_CYCLES, 10000, consecutive cycles a synchronised A/B value must differ from the stable value before it is accepted (100 us at 100 MHz); legal range >= 2.
BTN_DB_CYCLES, 2000000, same rule for the button channel (20 ms at 100 MHz); legal range >= 2.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
a_raw  input  1  raw encoder channel A, asynchronous, idle-high
b_raw  input  1  raw encoder channel B, asynchronous, idle-high
btn_raw  input  1  raw push button, asynchronous, active-high
a_db  output  1  debounced A level, to decoder A
b_db  output  1  debounced B level, to decoder B
btn_db  output  1  debounced button level, to decoder BTN
btn_press  output  1  one-cycle pulse on btn_db 0->1
btn_release  output  1  one-cycle pulse on btn_db 1->0
ab_change  output  1  one-cycle pulse when a_db or b_db changes

Behaviour:
- Decided interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values while reset is high, independent of clk:
  - A/B channels: sync flops = 1, a_db = 1, b_db = 1.
  - Button channel: sync flops = 0, btn_db = 0.
  - All counters = 0; btn_press = 0, btn_release = 0, ab_change = 0.
- Per channel, the three channels are identical and independent:
  - s1 <= raw; s2 <= s1 (2-flop synchroniser; s2 is the only value used downstream).
  - Counter width is $clog2(N) bits, where N = DB_CYCLES for A/B and BTN_DB_CYCLES for the button.
  - If s2 == stable: cnt <= 0.
  - If s2 != stable and cnt < N-1: cnt <= cnt+1.
  - If s2 != stable and cnt == N-1: stable <= s2, cnt <= 0.
  - Outputs a_db, b_db and btn_db are the stable registers directly (no combinational path from the raw pins).
- Latency: a raw level that changes and then holds appears on the output at rising edge N+2. Edge 1 is the first edge that samples the new level into s1.
- Glitch rejection:
  - Any return of s2 to the stable value before acceptance clears cnt to 0.
  - A pulse lasting N-1 cycles or fewer at s2 never reaches the output.
  - A later change restarts the count from 0; there is no accumulation.
- Pulses are registered and asserted on the same edge as the corresponding stable update, for exactly one cycle:
  - btn_press = 1 when btn_db goes 0->1.
  - btn_release = 1 when btn_db goes 1->0.
  - ab_change = 1 when a_db, b_db or both update on that edge.
- Simultaneous events:
  - A and B accepted on the same edge produce one ab_change pulse.
  - A button update never affects ab_change.
  - btn_press and btn_release are never high together.
- Reset mid-operation: a pending count is discarded, outputs return to their reset values immediately, and any pulse in flight is dropped.
- Steady mismatch: a counter saturating at N-1 cannot occur, because acceptance at N-1 clears it. Counters never wrap.
- Synthesis: sync flops carry an ASYNC_REG attribute. No latches; the single sequential process is asynchronously reset.

Test Plan:
All scenarios use DB_CYCLES=4 and BTN_DB_CYCLES=8.
- Reset: assert reset with random raw pins -> a_db=1, b_db=1, btn_db=0, all pulses 0 without a clock edge. Release reset with a_raw=b_raw=1 and btn_raw=0 held for 20 cycles -> outputs unchanged, no pulses.
- Clean A step: a_raw 1->0, sampled at edge 1 and held -> a_db=0 at edge 6 (N+2), not before. ab_change high for exactly that one cycle; b_db stays 1.
- Glitch reject: b_raw low for 3 cycles, then high -> b_db stays 1 and ab_change never asserts. Then hold b_raw low for 10 cycles -> b_db=0 at edge 6 after the hold begins.
- Simultaneous A/B: a_raw and b_raw both 1->0 on the same cycle -> both fall at edge 6, with a single one-cycle ab_change.
- Button: btn_raw bouncing 1,0,1,0 for one cycle each, then held 1 -> btn_db=1 at edge 10 after the hold begins, with btn_press for one cycle. Release and hold 0 -> btn_db=0 after 10 edges, with btn_release for one cycle; press and release never high together.
- Reset mid-count: a_raw low for 4 cycles, then pulse reset for 1 cycle with a_raw still low -> a_db=1 immediately. Counting restarts from the resynchronised value, so a_db=0 at edge 6 after reset deasserts.

Source files
------------

// File: rtl/rotary_input_conditioner.sv
// rtl/rotary_input_conditioner.sv - synchroniser, debouncer and edge pulses for rotary encoder A/B and button pins
module rotary_input_conditioner #(
    parameter int DB_CYCLES     = 10000,
    parameter int BTN_DB_CYCLES = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    input  logic btn_raw,
    output logic a_db,
    output logic b_db,
    output logic btn_db,
    output logic btn_press,
    output logic btn_release,
    output logic ab_change
);

    localparam int AB_W  = (DB_CYCLES     > 1) ? $clog2(DB_CYCLES)     : 1;
    localparam int BTN_W = (BTN_DB_CYCLES > 1) ? $clog2(BTN_DB_CYCLES) : 1;

    // Count value at which a persistent difference is accepted as the new level
    localparam logic [AB_W-1:0]  AB_LAST  = AB_W'(DB_CYCLES - 1);
    localparam logic [BTN_W-1:0] BTN_LAST = BTN_W'(BTN_DB_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic a_s1;
    (* ASYNC_REG = "TRUE" *) logic a_s2;
    (* ASYNC_REG = "TRUE" *) logic b_s1;
    (* ASYNC_REG = "TRUE" *) logic b_s2;
    (* ASYNC_REG = "TRUE" *) logic btn_s1;
    (* ASYNC_REG = "TRUE" *) logic btn_s2;

    logic [AB_W-1:0]  a_cnt;
    logic [AB_W-1:0]  b_cnt;
    logic [BTN_W-1:0] btn_cnt;

    logic a_accept;
    logic b_accept;
    logic btn_accept;

    // Acceptance fires on the edge where the difference has persisted for the full window
    always_comb begin
        a_accept   = (a_s2   != a_db)   && (a_cnt   == AB_LAST);
        b_accept   = (b_s2   != b_db)   && (b_cnt   == AB_LAST);
        btn_accept = (btn_s2 != btn_db) && (btn_cnt == BTN_LAST);
    end

    // Synchronise, debounce and pulse-generate all three channels in one reset domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_s1        <= 1'b1;
            a_s2        <= 1'b1;
            b_s1        <= 1'b1;
            b_s2        <= 1'b1;
            btn_s1      <= 1'b0;
            btn_s2      <= 1'b0;
            a_cnt       <= '0;
            b_cnt       <= '0;
            btn_cnt     <= '0;
            a_db        <= 1'b1;
            b_db        <= 1'b1;
            btn_db      <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            ab_change   <= 1'b0;
        end else begin
            a_s1   <= a_raw;
            a_s2   <= a_s1;
            b_s1   <= b_raw;
            b_s2   <= b_s1;
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;

            // Any return to the stable level restarts the window; no accumulation
            if (a_s2 == a_db) begin
                a_cnt <= '0;
            end else if (a_accept) begin
                a_db  <= a_s2;
                a_cnt <= '0;
            end else begin
                a_cnt <= a_cnt + 1'b1;
            end

            if (b_s2 == b_db) begin
                b_cnt <= '0;
            end else if (b_accept) begin
                b_db  <= b_s2;
                b_cnt <= '0;
            end else begin
                b_cnt <= b_cnt + 1'b1;
            end

            if (btn_s2 == btn_db) begin
                btn_cnt <= '0;
            end else if (btn_accept) begin
                btn_db  <= btn_s2;
                btn_cnt <= '0;
            end else begin
                btn_cnt <= btn_cnt + 1'b1;
            end

            // Pulses line up with the stable-register update they announce
            ab_change   <= a_accept | b_accept;
            btn_press   <= btn_accept &  btn_s2;
            btn_release <= btn_accept & ~btn_s2;
        end
    end

endmodule

// File: tb/tb_rotary_input_conditioner.sv
// tb/tb_rotary_input_conditioner.sv - directed table-driven bench for rotary_input_conditioner
module tb_rotary_input_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic a_raw, b_raw, btn_raw;
    logic a_db, b_db, btn_db, btn_press, btn_release, ab_change;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       a;
        logic       b;
        logic       btn;
        logic [5:0] exp;   // {a_db, b_db, btn_db, btn_press, btn_release, ab_change}
    } vec_t;

    vec_t tbl[$];

    rotary_input_conditioner #(
        .DB_CYCLES     (4),
        .BTN_DB_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_raw       (a_raw),
        .b_raw       (b_raw),
        .btn_raw     (btn_raw),
        .a_db        (a_db),
        .b_db        (b_db),
        .btn_db      (btn_db),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .ab_change   (ab_change)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {a_db, b_db, btn_db, btn_press, btn_release, ab_change};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (a_db b_db btn_db press release change)", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string name, input logic a, input logic b, input logic btn,
                       input logic [5:0] exp, input int n);
        vec_t v;
        v.name = name;
        v.a    = a;
        v.b    = b;
        v.btn  = btn;
        v.exp  = exp;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        // Reset with random pins must drive reset values before any clock edge
        reset   = 1'b1;
        a_raw   = 1'($urandom);
        b_raw   = 1'($urandom);
        btn_raw = 1'($urandom);
        #2;
        check("reset_no_clock", outs(), 6'b110000);
        a_raw   = 1'b1;
        b_raw   = 1'b1;
        btn_raw = 1'b0;
        tick();
        tick();
        check("reset_held", outs(), 6'b110000);
        reset = 1'b0;

        add("idle",          1, 1, 0, 6'b110000, 20);
        add("a_fall_wait",   0, 1, 0, 6'b110000, 5);
        add("a_fall_edge6",  0, 1, 0, 6'b010001, 1);
        add("a_fall_after",  0, 1, 0, 6'b010000, 1);
        add("a_rise_wait",   1, 1, 0, 6'b010000, 5);
        add("a_rise_edge6",  1, 1, 0, 6'b110001, 1);
        add("a_rise_after",  1, 1, 0, 6'b110000, 2);
        add("b_glitch_low",  1, 0, 0, 6'b110000, 3);
        add("b_glitch_high", 1, 1, 0, 6'b110000, 6);
        add("b_fall_wait",   1, 0, 0, 6'b110000, 5);
        add("b_fall_edge6",  1, 0, 0, 6'b100001, 1);
        add("b_fall_hold",   1, 0, 0, 6'b100000, 4);
        add("b_rise_wait",   1, 1, 0, 6'b100000, 5);
        add("b_rise_edge6",  1, 1, 0, 6'b110001, 1);
        add("ab_fall_wait",  0, 0, 0, 6'b110000, 5);
        add("ab_fall_edge6", 0, 0, 0, 6'b000001, 1);
        add("ab_fall_after", 0, 0, 0, 6'b000000, 1);
        add("ab_rise_wait",  1, 1, 0, 6'b000000, 5);
        add("ab_rise_edge6", 1, 1, 0, 6'b110001, 1);
        add("ab_rise_after", 1, 1, 0, 6'b110000, 1);
        add("btn_bounce1",   1, 1, 1, 6'b110000, 1);
        add("btn_bounce0",   1, 1, 0, 6'b110000, 1);
        add("btn_bounce1",   1, 1, 1, 6'b110000, 1);
        add("btn_bounce0",   1, 1, 0, 6'b110000, 1);
        add("btn_hold_wait", 1, 1, 1, 6'b110000, 9);
        add("btn_press",     1, 1, 1, 6'b111100, 1);
        add("btn_held",      1, 1, 1, 6'b111000, 1);
        add("btn_rel_wait",  1, 1, 0, 6'b111000, 9);
        add("btn_release",   1, 1, 0, 6'b110010, 1);
        add("btn_released",  1, 1, 0, 6'b110000, 1);

        foreach (tbl[i]) begin
            a_raw   = tbl[i].a;
            b_raw   = tbl[i].b;
            btn_raw = tbl[i].btn;
            tick();
            check(tbl[i].name, outs(), tbl[i].exp);
        end

        // Reset mid-count: pending count discarded, restart from resynchronised value
        a_raw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midcnt_pre", outs(), 6'b110000);
        end
        reset = 1'b1;
        #2;
        check("midcnt_reset_async", outs(), 6'b110000);
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i < 6)       check("midcnt_wait",  outs(), 6'b110000);
            else if (i == 6) check("midcnt_edge6", outs(), 6'b010001);
            else             check("midcnt_after", outs(), 6'b010000);
        end

        // Asynchronous reset with non-reset outputs must restore them without an edge
        btn_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i < 10) check("rst_btn_wait",  outs(), 6'b010000);
            else        check("rst_btn_press", outs(), 6'b011100);
        end
        reset = 1'b1;
        #1;
        check("reset_async_mid", outs(), 6'b110000);
        tick();
        check("reset_hold_mid", outs(), 6'b110000);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
